// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb,
// drives operand and strobe controls, and traps on illegal opcodes or a stalled bus.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic        mem_ready,
   input  logic        branch_taken,
   output logic        alu_src,
   output logic        imm_is_store,
   output logic [1:0]  alu_op,
   output logic        mem_read_en,
   output logic        mem_write_en,
   output logic        ir_load,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg_write_en,
   output logic        wb_sel,
   output logic        retire,
   output logic        trap,
   output logic [2:0]  state
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StFetch  = 3'd1;
   localparam logic [2:0] StDecode = 3'd2;
   localparam logic [2:0] StExec   = 3'd3;
   localparam logic [2:0] StMem    = 3'd4;
   localparam logic [2:0] StWb     = 3'd5;
   localparam logic [2:0] StTrap   = 3'd7;

   localparam logic [2:0] ClsNone   = 3'd0;
   localparam logic [2:0] ClsR      = 3'd1;
   localparam logic [2:0] ClsI      = 3'd2;
   localparam logic [2:0] ClsLoad   = 3'd3;
   localparam logic [2:0] ClsStore  = 3'd4;
   localparam logic [2:0] ClsBranch = 3'd5;

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpI      = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;

   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT - 1);

   logic [2:0]       state_q, state_d;
   logic [2:0]       class_q, class_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic             mem_wait;
   logic             unused_instr;

   // Only the opcode field steers control; the rest of the IR feeds the datapath.
   assign unused_instr = ^instruction[31:7];

   always_comb begin
      state_d  = state_q;
      class_d  = class_q;
      wait_d   = '0;
      mem_wait = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
      case (state_q)
         StIdle:   state_d = StFetch;
         StFetch:  if (mem_ready) state_d = StDecode;
         StDecode: begin
            state_d = StExec;
            case (instruction[6:0])
               OpR:      class_d = ClsR;
               OpI:      class_d = ClsI;
               OpLoad:   class_d = ClsLoad;
               OpStore:  class_d = ClsStore;
               OpBranch: class_d = ClsBranch;
               default: begin
                  class_d = ClsNone;
                  state_d = StTrap;
               end
            endcase
         end
         StExec: begin
            case (class_q)
               ClsR, ClsI:        state_d = StWb;
               ClsLoad, ClsStore: state_d = StMem;
               ClsBranch:         state_d = StFetch;
               default:           state_d = StTrap;
            endcase
         end
         StMem:   if (mem_ready) state_d = (class_q == ClsLoad) ? StWb : StFetch;
         StWb:    state_d = StFetch;
         StTrap:  state_d = StTrap;
         default: state_d = StTrap;
      endcase
      // Counter is zero whenever not stalled, so every entry to FETCH/MEM starts clean.
      if (mem_wait) begin
         if (wait_q == WaitMax) begin
            state_d = StTrap;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         class_q <= ClsNone;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      alu_src      = 1'b0;
      imm_is_store = 1'b0;
      alu_op       = 2'b00;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      ir_load      = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      reg_write_en = 1'b0;
      wb_sel       = 1'b0;
      retire       = 1'b0;
      trap         = 1'b0;
      case (state_q)
         StFetch: begin
            mem_read_en = 1'b1;
            ir_load     = mem_ready;
         end
         StExec: begin
            case (class_q)
               ClsR: alu_op = 2'b01;
               ClsI: begin
                  alu_src = 1'b1;
                  alu_op  = 2'b01;
               end
               ClsLoad: alu_src = 1'b1;
               ClsStore: begin
                  alu_src      = 1'b1;
                  imm_is_store = 1'b1;
               end
               ClsBranch: begin
                  alu_op   = 2'b10;
                  pc_write = 1'b1;
                  pc_src   = branch_taken;
                  retire   = 1'b1;
               end
               default: ;
            endcase
         end
         StMem: begin
            if (class_q == ClsLoad) begin
               mem_read_en = 1'b1;
            end else begin
               mem_write_en = 1'b1;
               pc_write     = mem_ready;
               retire       = mem_ready;
            end
         end
         StWb: begin
            reg_write_en = 1'b1;
            wb_sel       = (class_q == ClsLoad);
            pc_write     = 1'b1;
            retire       = 1'b1;
         end
         StTrap:  trap = 1'b1;
         default: ;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction scenarios plus random traffic,
// every cycle compared against a per-instruction behavioural model.
module tb_multicycle_ctrl;

   localparam int unsigned TO = 4;
   localparam logic [31:0] ADDI = 32'h00500093;
   localparam logic [31:0] SW   = 32'h0020A423;
   localparam logic [31:0] LW   = 32'h0000A103;
   localparam logic [31:0] BEQ  = 32'h00208463;
   localparam logic [31:0] ILL  = 32'h0000007F;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instruction = '0;
   logic        mem_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic        alu_src, imm_is_store, mem_read_en, mem_write_en, ir_load;
   logic        pc_write, pc_src, reg_write_en, wb_sel, retire, trap;
   logic [1:0]  alu_op;
   logic [2:0]  state;
   logic [15:0] dut_vec;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
      .branch_taken(branch_taken), .alu_src(alu_src), .imm_is_store(imm_is_store),
      .alu_op(alu_op), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .reg_write_en(reg_write_en),
      .wb_sel(wb_sel), .retire(retire), .trap(trap), .state(state)
   );

   assign dut_vec = {alu_src, imm_is_store, alu_op, mem_read_en, mem_write_en, ir_load,
                     pc_write, pc_src, reg_write_en, wb_sel, retire, trap, state};

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: phase of the current instruction (spec state codes), its class and stall count.
   // Classes: 0 none, 1 R, 2 I, 3 load, 4 store, 5 branch.
   int m_st = 0;
   int m_cls = 0;
   int m_wait = 0;

   function automatic int classify(input logic [6:0] op);
      case (op)
         7'b0110011: return 1;
         7'b0010011: return 2;
         7'b0000011: return 3;
         7'b0100011: return 4;
         7'b1100011: return 5;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [15:0] model_out();
      logic a_src, imm, rd, wr, irl, pcw, pcs, rw, wbs, ret, trp;
      logic [1:0] op;
      {a_src, imm, rd, wr, irl, pcw, pcs, rw, wbs, ret, trp} = '0;
      op = 2'b00;
      case (m_st)
         1: begin rd = 1'b1; irl = mem_ready; end
         3: begin
            a_src = (m_cls == 2) || (m_cls == 3) || (m_cls == 4);
            imm   = (m_cls == 4);
            op    = (m_cls == 1 || m_cls == 2) ? 2'b01 : (m_cls == 5) ? 2'b10 : 2'b00;
            if (m_cls == 5) begin pcw = 1'b1; pcs = branch_taken; ret = 1'b1; end
         end
         4: begin
            rd = (m_cls == 3);
            wr = (m_cls == 4);
            if (m_cls == 4 && mem_ready) begin pcw = 1'b1; ret = 1'b1; end
         end
         5: begin rw = 1'b1; wbs = (m_cls == 3); pcw = 1'b1; ret = 1'b1; end
         7: trp = 1'b1;
         default: ;
      endcase
      return {a_src, imm, op, rd, wr, irl, pcw, pcs, rw, wbs, ret, trp, 3'(m_st)};
   endfunction

   always @(posedge clk) begin
      int nxt;
      if (!rst_n) begin
         m_st = 0; m_cls = 0; m_wait = 0;
      end else begin
         nxt = m_st;
         case (m_st)
            0: nxt = 1;
            1: if (mem_ready) nxt = 2;
            2: begin
               m_cls = classify(instruction[6:0]);
               nxt = (m_cls == 0) ? 7 : 3;
            end
            3: nxt = (m_cls == 5) ? 1 : (m_cls >= 3) ? 4 : 5;
            4: if (mem_ready) nxt = (m_cls == 3) ? 5 : 1;
            5: nxt = 1;
            default: ;
         endcase
         if ((m_st == 1 || m_st == 4) && !mem_ready) begin
            if (m_wait == int'(TO) - 1) nxt = 7;
            else m_wait++;
         end
         if (nxt != m_st && (nxt == 1 || nxt == 4)) m_wait = 0;
         m_st = nxt;
      end
   end

   always @(negedge clk) begin
      #2;
      if (chk_en) check("cycle_outputs", {16'h0, dut_vec}, {16'h0, model_out()});
   end

   task automatic tick(input logic [31:0] ins, input logic rdy, input logic bt, input logic rs);
      @(negedge clk);
      instruction  = ins;
      mem_ready    = rdy;
      branch_taken = bt;
      rst_n        = rs;
      #3;
   endtask

   int t1_st[5] = '{0, 1, 2, 3, 5};
   int t3_st[5] = '{1, 2, 3, 4, 5};
   logic [6:0] ops[6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7f};

   initial begin
      int cnt_a, cnt_b, trap_run;
      logic [31:0] ins;

      // Reset state
      tick(ADDI, 1'b1, 1'b0, 1'b0);
      chk_en = 1'b1;
      check("reset_state", state, 3'd0);
      check("reset_outputs", dut_vec, 16'h0);

      // ADDI: states 0,1,2,3,5 then FETCH
      for (int i = 0; i < 5; i++) begin
         tick(ADDI, 1'b1, 1'b0, 1'b1);
         check("addi_state", state, t1_st[i]);
         if (i == 3) check("addi_exec_ctl", {alu_src, imm_is_store, alu_op}, 4'b1001);
         if (i == 4) check("addi_wb_ctl", {reg_write_en, wb_sel, retire}, 3'b101);
      end

      // SW with two stall cycles in MEM
      cnt_a = 0; cnt_b = 0;
      tick(SW, 1'b1, 1'b0, 1'b1); check("sw_fetch_state", state, 3'd1);
      tick(SW, 1'b1, 1'b0, 1'b1); check("sw_decode_state", state, 3'd2);
      tick(SW, 1'b1, 1'b0, 1'b1); check("sw_exec_ctl", {state, alu_src, imm_is_store}, 5'b01111);
      cnt_b += int'(reg_write_en);
      for (int k = 0; k < 3; k++) begin
         tick(SW, k == 2, 1'b0, 1'b1);
         check("sw_mem_state", state, 3'd4);
         cnt_a += int'(mem_write_en);
         cnt_b += int'(reg_write_en);
         if (k == 2) check("sw_done", {pc_write, pc_src, retire}, 3'b101);
         else check("sw_wait", {pc_write, retire}, 2'b00);
      end
      check("sw_write_cycles", cnt_a, 3);
      check("sw_no_regwrite", cnt_b, 0);

      // LW: five cycles, one retire
      cnt_a = 0;
      for (int i = 0; i < 5; i++) begin
         tick(LW, 1'b1, 1'b0, 1'b1);
         check("lw_state", state, t3_st[i]);
         cnt_a += int'(retire);
         if (i == 3) check("lw_mem_read", {mem_read_en, mem_write_en}, 2'b10);
         if (i == 4) check("lw_wb_sel", {reg_write_en, wb_sel}, 2'b11);
      end
      check("lw_retire_count", cnt_a, 1);

      // BEQ taken, then not taken
      for (int t = 1; t >= 0; t--) begin
         tick(BEQ, 1'b1, t[0], 1'b1); check("beq_fetch", state, 3'd1);
         tick(BEQ, 1'b1, t[0], 1'b1); check("beq_decode", state, 3'd2);
         tick(BEQ, 1'b1, t[0], 1'b1);
         check("beq_exec", {state, alu_op, pc_write, pc_src, retire}, {3'd3, 2'b10, 1'b1, t[0], 1'b1});
      end

      // Illegal opcode traps and stays trapped
      tick(ILL, 1'b1, 1'b0, 1'b1); check("ill_fetch", state, 3'd1);
      tick(ILL, 1'b1, 1'b0, 1'b1); check("ill_decode", state, 3'd2);
      cnt_a = 0;
      for (int i = 0; i < 20; i++) begin
         tick($urandom, 1'($urandom), 1'($urandom), 1'b1);
         cnt_a += int'(trap && state == 3'd7);
      end
      check("ill_trap_cycles", cnt_a, 20);
      tick(ILL, 1'b0, 1'b0, 1'b0);
      tick(ILL, 1'b0, 1'b0, 1'b1); check("trap_reset", {state, trap}, 4'b0000);

      // Watchdog: four stalled FETCH cycles trap
      for (int i = 0; i < 4; i++) begin
         tick(ADDI, 1'b0, 1'b0, 1'b1); check("wd_fetch", state, 3'd1);
      end
      tick(ADDI, 1'b0, 1'b0, 1'b1); check("wd_trap", {state, trap}, 4'b1111);
      tick(ADDI, 1'b0, 1'b0, 1'b0);
      tick(ADDI, 1'b0, 1'b0, 1'b1); check("wd_reset", state, 3'd0);
      // Ready on the last allowed cycle wins
      for (int i = 0; i < 4; i++) begin
         tick(SW, i == 3, 1'b0, 1'b1); check("wd_edge_fetch", state, 3'd1);
      end
      tick(SW, 1'b1, 1'b0, 1'b1); check("wd_edge_decode", state, 3'd2);
      tick(SW, 1'b1, 1'b0, 1'b1); check("mid_exec", state, 3'd3);
      // Reset mid-MEM aborts the store
      tick(SW, 1'b0, 1'b0, 1'b0); check("mid_mem", {state, mem_write_en}, 4'b1001);
      tick(SW, 1'b0, 1'b0, 1'b1); check("mid_reset_idle", state, 3'd0);
      cnt_a = int'(mem_write_en);
      for (int i = 0; i < 3; i++) begin
         tick(SW, 1'b0, 1'b0, 1'b1);
         cnt_a += int'(mem_write_en);
      end
      check("mid_no_write", cnt_a, 0);

      // Random traffic
      trap_run = 0;
      for (int n = 0; n < 3000; n++) begin
         ins = $urandom;
         if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 5)];
         tick(ins, $urandom_range(0, 3) != 0, 1'($urandom),
              ($urandom_range(0, 63) != 0) && (trap_run < 6));
         trap_run = (m_st == 7) ? trap_run + 1 : 0;
      end

      @(negedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
